// File: rtl/priority_pkg.sv
// Shared definitions for the cluster priority sequencer.
//   state_t         sequencer FSM states
//   DEF_*           default widths and the empty-slot address
//   pad_rec_t       one pad record {vpf, cnt, adr} at the default widths
//   clog2           ceiling log2, used for address-width checks and index sizing
//   tree_levels     number of pairwise reduction levels needed for n leaves
package priority_pkg;

  typedef enum logic [1:0] {IDLE, SEARCH, EVAL, DONE} state_t;

  localparam int DEF_MXCNTBITS = 3;
  localparam int DEF_MXADRBITS = 11;
  localparam logic [DEF_MXADRBITS-1:0] DEF_INVALID_ADR = 11'h7FE;

  typedef struct packed {
    logic                     vpf;
    logic [DEF_MXCNTBITS-1:0] cnt;
    logic [DEF_MXADRBITS-1:0] adr;
  } pad_rec_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int tree_levels(input int n);
    int lv;
    int wd;
    lv = 0;
    wd = n;
    while (wd > 1) begin
      wd = (wd + 1) / 2;
      lv++;
    end
    return lv;
  endfunction

endpackage

// File: rtl/priority_tree.sv
// Lowest-index-wins binary reduction tree over WIDTH pads.
// Each level pairs neighbours; an odd last node is paired with a vpf=0 leaf,
// so any width works. Level widths for 1536: 768,384,192,96,48,...,1.
// Optional macro PRIORITY_PIPE_EN: nodes of level PIPE_LEVEL are registered
// (level 4 = the 96-wide level for 1536 pads), adding one clock of latency.
// Ports:
//   clock, global_reset  only present with PRIORITY_PIPE_EN (async, active-high)
//   vpfs  in  WIDTH          per-pad valid flags
//   cnts  in  WIDTH*CNTBITS  per-pad counts
//   any   out 1              at least one vpf set
//   adr   out ADRBITS        lowest set pad index
//   cnt   out CNTBITS        count of that pad
module priority_tree
  import priority_pkg::*;
#(
  parameter int WIDTH      = 1536,
  parameter int CNTBITS    = 3,
  parameter int ADRBITS    = 11,
  parameter int PIPE_LEVEL = 4
) (
`ifdef PRIORITY_PIPE_EN
  input  logic                       clock,
  input  logic                       global_reset,
`endif
  input  logic [WIDTH-1:0]           vpfs,
  input  logic [WIDTH*CNTBITS-1:0]   cnts,
  output logic                       any,
  output logic [ADRBITS-1:0]         adr,
  output logic [CNTBITS-1:0]         cnt
);

  localparam int NLEV = tree_levels(WIDTH);

  function automatic int level_width(input int lvl);
    int wd;
    wd = WIDTH;
    for (int i = 0; i < lvl; i++) wd = (wd + 1) / 2;
    return wd;
  endfunction

  genvar gi, gj;
  for (gi = 0; gi <= NLEV; gi++) begin : g_lvl
    localparam int W = level_width(gi);
    logic               node_vpf [W];
    logic [CNTBITS-1:0] node_cnt [W];
    logic [ADRBITS-1:0] node_adr [W];

    if (gi == 0) begin : g_leaf
      for (gj = 0; gj < W; gj++) begin : g_pad
        assign node_vpf[gj] = vpfs[gj];
        assign node_cnt[gj] = cnts[gj*CNTBITS +: CNTBITS];
        assign node_adr[gj] = ADRBITS'(gj);
      end
    end else begin : g_merge
      localparam int PW = level_width(gi - 1);
      logic               sel_vpf [W];
      logic [CNTBITS-1:0] sel_cnt [W];
      logic [ADRBITS-1:0] sel_adr [W];

      for (gj = 0; gj < W; gj++) begin : g_node
        logic               l_vpf, r_vpf;
        logic [CNTBITS-1:0] l_cnt, r_cnt;
        logic [ADRBITS-1:0] l_adr, r_adr;

        assign l_vpf = g_lvl[gi-1].node_vpf[2*gj];
        assign l_cnt = g_lvl[gi-1].node_cnt[2*gj];
        assign l_adr = g_lvl[gi-1].node_adr[2*gj];

        if (2*gj + 1 < PW) begin : g_pair
          assign r_vpf = g_lvl[gi-1].node_vpf[2*gj+1];
          assign r_cnt = g_lvl[gi-1].node_cnt[2*gj+1];
          assign r_adr = g_lvl[gi-1].node_adr[2*gj+1];
        end else begin : g_empty
          assign r_vpf = 1'b0;
          assign r_cnt = '0;
          assign r_adr = '0;
        end

        // Left child holds the lower indices, so it wins whenever it is valid.
        assign sel_vpf[gj] = l_vpf | r_vpf;
        assign sel_cnt[gj] = l_vpf ? l_cnt : r_cnt;
        assign sel_adr[gj] = l_vpf ? l_adr : r_adr;
      end

`ifdef PRIORITY_PIPE_EN
      localparam int PIPE_AT = (PIPE_LEVEL < NLEV) ? PIPE_LEVEL : NLEV;
      if (gi == PIPE_AT) begin : g_reg
        always_ff @(posedge clock or posedge global_reset) begin
          if (global_reset) begin
            node_vpf <= '{default: 1'b0};
            node_cnt <= '{default: '0};
            node_adr <= '{default: '0};
          end else begin
            node_vpf <= sel_vpf;
            node_cnt <= sel_cnt;
            node_adr <= sel_adr;
          end
        end
      end else begin : g_wire
        assign node_vpf = sel_vpf;
        assign node_cnt = sel_cnt;
        assign node_adr = sel_adr;
      end
`else
      assign node_vpf = sel_vpf;
      assign node_cnt = sel_cnt;
      assign node_adr = sel_adr;
`endif
    end
  end

  assign any = g_lvl[NLEV].node_vpf[0];
  assign adr = g_lvl[NLEV].node_adr[0];
  assign cnt = g_lvl[NLEV].node_cnt[0];

endmodule

// File: rtl/cluster_priority_sequencer.sv
// Latches one BX of pad VPFs and counts, then extracts up to MXCLUSTERS
// lowest-address valid pads, one per search step, masking each winner.
// Optional macro PRIORITY_PIPE_EN: registered tree midpoint; each step
// becomes EVAL + SEARCH(commit), two clocks.
// Ports:
//   clock         in   system clock
//   global_reset  in   asynchronous active-high reset
//   latch_delay   in   latch_in delay 0..15 (0 -> 1 clk, else latch_delay+1 clks)
//   latch_in      in   BX strobe
//   vpfs_in       in   per-pad valid flags
//   cnts_in       in   per-pad counts, pad i at [i*MXCNTBITS +: MXCNTBITS]
//   adr_out       out  slot addresses, slot 0 = lowest pad, INVALID_ADR when empty
//   cnt_out       out  slot counts
//   vld_out       out  slot holds a real pad
//   busy          out  extraction in progress
//   done          out  one-clock pulse when slots are final
//   overflow      out  valid pads remained after all slots filled
module cluster_priority_sequencer
  import priority_pkg::*;
#(
  parameter int MXPADS     = 1536,
  parameter int MXCNTBITS  = 3,
  parameter int MXADRBITS  = 11,
  parameter int MXCLUSTERS = 8,
  parameter logic [MXADRBITS-1:0] INVALID_ADR = MXADRBITS'(DEF_INVALID_ADR)
) (
  input  logic                            clock,
  input  logic                            global_reset,
  input  logic [3:0]                      latch_delay,
  input  logic                            latch_in,
  input  logic [MXPADS-1:0]               vpfs_in,
  input  logic [MXPADS*MXCNTBITS-1:0]     cnts_in,
  output logic [MXCLUSTERS*MXADRBITS-1:0] adr_out,
  output logic [MXCLUSTERS*MXCNTBITS-1:0] cnt_out,
  output logic [MXCLUSTERS-1:0]           vld_out,
  output logic                            busy,
  output logic                            done,
  output logic                            overflow
);

  localparam int IDXBITS = (MXCLUSTERS > 1) ? clog2(MXCLUSTERS) : 1;
  localparam logic [IDXBITS-1:0] LAST_IDX = IDXBITS'(MXCLUSTERS - 1);

`ifdef PRIORITY_PIPE_EN
  localparam state_t STEP_STATE = EVAL;
`else
  localparam state_t STEP_STATE = SEARCH;
`endif

  // The empty-slot code and the sentinel must stay outside the pad range.
  if (MXADRBITS < clog2(MXPADS + 2)) begin : g_adr_check
    $error("MXADRBITS too small: need 2**MXADRBITS > MXPADS+1");
  end

  // Latch delay line: tap 0 is latch_in itself, tap d is latch_in delayed d
  // clocks; the latch_en register adds one more clock.
  logic [14:0] latch_sr_reg;
  logic [15:0] latch_taps;
  logic        latch_en_reg;

  assign latch_taps = {latch_sr_reg, latch_in};

  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      latch_sr_reg <= '0;
      latch_en_reg <= 1'b0;
    end else begin
      latch_sr_reg <= latch_taps[14:0];
      latch_en_reg <= latch_taps[latch_delay];
    end
  end

  logic [MXPADS-1:0]           mask_reg;
  logic [MXPADS-1:0]           mask_taken;
  logic [MXPADS*MXCNTBITS-1:0] cnts_reg;
  logic [IDXBITS-1:0]          idx_reg;
  state_t                      state_reg, state_next;
  logic                        take, finish;

  logic                 tree_any;
  logic [MXADRBITS-1:0] tree_adr;
  logic [MXCNTBITS-1:0] tree_cnt;

  priority_tree #(
    .WIDTH   (MXPADS),
    .CNTBITS (MXCNTBITS),
    .ADRBITS (MXADRBITS)
  ) u_tree (
`ifdef PRIORITY_PIPE_EN
    .clock        (clock),
    .global_reset (global_reset),
`endif
    .vpfs (mask_reg),
    .cnts (cnts_reg),
    .any  (tree_any),
    .adr  (tree_adr),
    .cnt  (tree_cnt)
  );

  // Mask with the current winner removed; also feeds the overflow test.
  always_comb begin
    mask_taken = mask_reg;
    mask_taken[tree_adr] = 1'b0;
  end

  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) state_reg <= IDLE;
    else              state_reg <= state_next;
  end

  // A load overrides every state, which is what aborts a BX in flight.
  always_comb begin
    state_next = state_reg;
    take       = 1'b0;
    finish     = 1'b0;
    if (latch_en_reg) begin
      state_next = STEP_STATE;
    end else begin
      case (state_reg)
        IDLE:   state_next = IDLE;
        EVAL:   state_next = SEARCH;
        SEARCH: begin
          take       = tree_any;
          state_next = (!tree_any || idx_reg == LAST_IDX) ? DONE : STEP_STATE;
        end
        DONE: begin
          finish     = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      mask_reg <= '0;
      cnts_reg <= '0;
      idx_reg  <= '0;
      adr_out  <= {MXCLUSTERS{INVALID_ADR}};
      cnt_out  <= '0;
      vld_out  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= finish;
      if (latch_en_reg) begin
        mask_reg <= vpfs_in;
        cnts_reg <= cnts_in;
        idx_reg  <= '0;
        adr_out  <= {MXCLUSTERS{INVALID_ADR}};
        cnt_out  <= '0;
        vld_out  <= '0;
        overflow <= 1'b0;
        busy     <= 1'b1;
      end else begin
        if (take) begin
          adr_out[idx_reg*MXADRBITS +: MXADRBITS] <= tree_adr;
          cnt_out[idx_reg*MXCNTBITS +: MXCNTBITS] <= tree_cnt;
          vld_out[idx_reg]                        <= 1'b1;
          mask_reg                                <= mask_taken;
          idx_reg                                 <= idx_reg + 1'b1;
          if (idx_reg == LAST_IDX) overflow <= |mask_taken;
        end
        if (finish) busy <= 1'b0;
      end
    end
  end

endmodule
